// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if
// Groups every non-clock signal of the ID/EX operand stage into one bundle.
//   master : the surrounding pipeline (ID stage, EX/MEM and MEM/WB forwarding
//            sources); drives stall/flush, the d_* decode fields and the m_* / w_*
//            forwarding sources, and receives the hazard request and EX outputs.
//   slave  : ex_operand_stage itself.
// Signal groups:
//   control   : stall, flush
//   decode    : d_valid, d_rs, d_rt, d_rn, d_use_rs, d_use_rt, d_rs_data,
//               d_rt_data, d_imm, d_sa, d_aluc, d_aluimm, d_shift, d_wreg,
//               d_m2reg, d_wmem
//   forward   : m_rn, m_wreg, m_m2reg, m_alu, w_rn, w_wreg, w_data
//   outputs   : load_use, a, b, aluc, e_valid, e_wreg, e_m2reg, e_wmem, e_rn,
//               e_store_data
interface ex_operand_stage_if;
    logic        stall;
    logic        flush;

    logic        d_valid;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [4:0]  d_rn;
    logic        d_use_rs;
    logic        d_use_rt;
    logic [31:0] d_rs_data;
    logic [31:0] d_rt_data;
    logic [31:0] d_imm;
    logic [4:0]  d_sa;
    logic [3:0]  d_aluc;
    logic        d_aluimm;
    logic        d_shift;
    logic        d_wreg;
    logic        d_m2reg;
    logic        d_wmem;

    logic [4:0]  m_rn;
    logic        m_wreg;
    logic        m_m2reg;
    logic [31:0] m_alu;
    logic [4:0]  w_rn;
    logic        w_wreg;
    logic [31:0] w_data;

    logic        load_use;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic        e_valid;
    logic        e_wreg;
    logic        e_m2reg;
    logic        e_wmem;
    logic [4:0]  e_rn;
    logic [31:0] e_store_data;

    modport master (
        output stall, flush,
        output d_valid, d_rs, d_rt, d_rn, d_use_rs, d_use_rt, d_rs_data,
               d_rt_data, d_imm, d_sa, d_aluc, d_aluimm, d_shift, d_wreg,
               d_m2reg, d_wmem,
        output m_rn, m_wreg, m_m2reg, m_alu, w_rn, w_wreg, w_data,
        input  load_use, a, b, aluc, e_valid, e_wreg, e_m2reg, e_wmem, e_rn,
               e_store_data
    );

    modport slave (
        input  stall, flush,
        input  d_valid, d_rs, d_rt, d_rn, d_use_rs, d_use_rt, d_rs_data,
               d_rt_data, d_imm, d_sa, d_aluc, d_aluimm, d_shift, d_wreg,
               d_m2reg, d_wmem,
        input  m_rn, m_wreg, m_m2reg, m_alu, w_rn, w_wreg, w_data,
        output load_use, a, b, aluc, e_valid, e_wreg, e_m2reg, e_wmem, e_rn,
               e_store_data
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ID/EX pipeline register and operand assembly in front of the 32-bit alu.
// Captures the decoded instruction each cycle, resolves EX/MEM and MEM/WB
// forwarding for rs and rt, raises load_use for a load followed by a dependent
// instruction, and drives the ALU operands plus the EX/MEM control bits.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset, clears every EX register
//   bus    : ex_operand_stage_if.slave (decode fields, forwarding sources,
//            stall/flush in; load_use, a, b, aluc, e_* out)
module ex_operand_stage (
    input  logic                      clock,
    input  logic                      resetn,
    ex_operand_stage_if.slave         bus
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  sa;
        logic [3:0]  aluc;
        logic        aluimm;
        logic        shift;
        logic [4:0]  rn;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
    } ex_t;

    ex_t         ex;
    ex_t         ex_next;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic        hazard;

    // MEM beats WB; a load sitting in MEM only has an address in m_alu, so it
    // must never be forwarded. Register 0 always reads its stored value.
    function automatic logic [31:0] forward(
        input logic [4:0]  r,
        input logic [31:0] stored,
        input logic [4:0]  m_rn,
        input logic        m_wreg,
        input logic        m_m2reg,
        input logic [31:0] m_alu,
        input logic [4:0]  w_rn,
        input logic        w_wreg,
        input logic [31:0] w_data
    );
        logic [31:0] result;
        result = stored;
        if (r != 5'd0) begin
            if (m_wreg && !m_m2reg && (m_rn == r))
                result = m_alu;
            else if (w_wreg && (w_rn == r))
                result = w_data;
        end
        return result;
    endfunction

    assign fwd_rs = forward(ex.rs, ex.rs_data, bus.m_rn, bus.m_wreg, bus.m_m2reg,
                            bus.m_alu, bus.w_rn, bus.w_wreg, bus.w_data);
    assign fwd_rt = forward(ex.rt, ex.rt_data, bus.m_rn, bus.m_wreg, bus.m_m2reg,
                            bus.m_alu, bus.w_rn, bus.w_wreg, bus.w_data);

    // A load in EX cannot supply its data yet, so a dependent instruction in ID
    // has to wait one cycle; afterwards the value arrives through MEM/WB.
    assign hazard = ex.valid & ex.wreg & ex.m2reg & (ex.rn != 5'd0) &
                    ((bus.d_use_rs & (bus.d_rs == ex.rn)) |
                     (bus.d_use_rt & (bus.d_rt == ex.rn)));

    // Next EX contents. While stalled the stored operands are refreshed with the
    // forwarded values, because a WB result is only on w_data for one cycle and
    // would otherwise be lost before the stall releases.
    always_comb begin
        ex_next = ex;
        if (bus.flush) begin
            ex_next = '0;
        end else if (bus.stall) begin
            ex_next.rs_data = fwd_rs;
            ex_next.rt_data = fwd_rt;
        end else if (hazard) begin
            ex_next = '0;
        end else begin
            ex_next.valid   = bus.d_valid;
            ex_next.rs      = bus.d_rs;
            ex_next.rt      = bus.d_rt;
            ex_next.rs_data = bus.d_rs_data;
            ex_next.rt_data = bus.d_rt_data;
            ex_next.imm     = bus.d_imm;
            ex_next.sa      = bus.d_sa;
            ex_next.aluc    = bus.d_aluc;
            ex_next.aluimm  = bus.d_aluimm;
            ex_next.shift   = bus.d_shift;
            ex_next.rn      = bus.d_rn;
            ex_next.wreg    = bus.d_wreg & bus.d_valid;
            ex_next.m2reg   = bus.d_m2reg;
            ex_next.wmem    = bus.d_wmem & bus.d_valid;
        end
    end

    // EX register bank; reset also discards anything held by a stall.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            ex <= '0;
        else
            ex <= ex_next;
    end

    // Operand assembly and registered control outputs.
    assign bus.a            = ex.shift  ? {27'b0, ex.sa} : fwd_rs;
    assign bus.b            = ex.aluimm ? ex.imm : fwd_rt;
    assign bus.e_store_data = fwd_rt;
    assign bus.aluc         = ex.aluc;
    assign bus.e_valid      = ex.valid;
    assign bus.e_wreg       = ex.wreg;
    assign bus.e_m2reg      = ex.m2reg;
    assign bus.e_wmem       = ex.wmem;
    assign bus.e_rn         = ex.rn;
    assign bus.load_use     = hazard;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage
// Self-checking bench for ex_operand_stage. Each scenario task drives stimulus,
// pushes the required output snapshot to a scoreboard queue, records the DUT's
// snapshot when it is due, and compares the two queues at the end of the task.
module tb_ex_operand_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic        valid;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  rn;
        logic [31:0] store;
        logic        lu;
    } obs_t;

    logic clock;
    logic resetn;
    int   tests_run;
    int   tests_failed;

    obs_t  exp_q[$];
    obs_t  got_q[$];
    string name_q[$];

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic obs_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] aluc, input logic valid,
                                input logic wreg, input logic m2reg, input logic wmem,
                                input logic [4:0] rn, input logic [31:0] store,
                                input logic lu);
        obs_t o;
        o.a = a; o.b = b; o.aluc = aluc; o.valid = valid; o.wreg = wreg;
        o.m2reg = m2reg; o.wmem = wmem; o.rn = rn; o.store = store; o.lu = lu;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("a=%h b=%h aluc=%b v=%b wreg=%b m2reg=%b wmem=%b rn=%0d st=%h lu=%b",
                         o.a, o.b, o.aluc, o.valid, o.wreg, o.m2reg, o.wmem, o.rn, o.store, o.lu);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string n, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Let combinational outputs settle, then record the DUT's view.
    task automatic observe();
        obs_t g;
        #1;
        g.a = bus.a; g.b = bus.b; g.aluc = bus.aluc; g.valid = bus.e_valid;
        g.wreg = bus.e_wreg; g.m2reg = bus.e_m2reg; g.wmem = bus.e_wmem;
        g.rn = bus.e_rn; g.store = bus.e_store_data; g.lu = bus.load_use;
        got_q.push_back(g);
    endtask

    task automatic idle();
        bus.stall = 0; bus.flush = 0;
        bus.d_valid = 0; bus.d_rs = 0; bus.d_rt = 0; bus.d_rn = 0;
        bus.d_use_rs = 0; bus.d_use_rt = 0; bus.d_rs_data = 0; bus.d_rt_data = 0;
        bus.d_imm = 0; bus.d_sa = 0; bus.d_aluc = 0; bus.d_aluimm = 0;
        bus.d_shift = 0; bus.d_wreg = 0; bus.d_m2reg = 0; bus.d_wmem = 0;
        bus.m_rn = 0; bus.m_wreg = 0; bus.m_m2reg = 0; bus.m_alu = 0;
        bus.w_rn = 0; bus.w_wreg = 0; bus.w_data = 0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rn, input logic use_rs, input logic use_rt,
                            input logic [31:0] rs_data, input logic [31:0] rt_data,
                            input logic [31:0] imm, input logic [4:0] sa,
                            input logic [3:0] aluc, input logic aluimm, input logic shift,
                            input logic wreg, input logic m2reg, input logic wmem);
        bus.d_valid = v; bus.d_rs = rs; bus.d_rt = rt; bus.d_rn = rn;
        bus.d_use_rs = use_rs; bus.d_use_rt = use_rt;
        bus.d_rs_data = rs_data; bus.d_rt_data = rt_data; bus.d_imm = imm;
        bus.d_sa = sa; bus.d_aluc = aluc; bus.d_aluimm = aluimm; bus.d_shift = shift;
        bus.d_wreg = wreg; bus.d_m2reg = m2reg; bus.d_wmem = wmem;
    endtask

    // Outputs stay 0 under reset whatever ID presents, then the first edge captures.
    task automatic test_reset();
        obs_t e, g; string n;
        resetn = 0;
        idle();
        drive_id(1, 5'd1, 5'd2, 5'd3, 1, 1, 32'd5, 32'd7, 32'hABCD, 5'd9, 4'b0000, 0, 0, 1, 0, 0);
        tick(); tick();
        expect_out("reset_outputs_zero", mk(0, 0, 4'b0000, 0, 0, 0, 0, 5'd0, 0, 0));
        observe();
        @(negedge clock);
        resetn = 1;
        expect_out("release_before_edge", mk(0, 0, 4'b0000, 0, 0, 0, 0, 5'd0, 0, 0));
        observe();
        tick();
        expect_out("first_capture_add", mk(32'd5, 32'd7, 4'b0000, 1, 1, 0, 0, 5'd3, 32'd7, 0));
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("[TB] FAIL %s: no output observed, required %s", n, fmt(e)); end
            else begin g = got_q.pop_front();
                if (g !== e) begin tests_failed++; $display("[TB] FAIL %s: got %s | required %s", n, fmt(g), fmt(e)); end
            end
        end
    endtask

    // MEM over WB, loads in MEM skipped, rt path, and register 0 never forwarded.
    task automatic test_forwarding();
        obs_t e, g; string n;
        idle();
        drive_id(1, 5'd3, 5'd6, 5'd7, 1, 1, 32'hAAAA, 32'hBBBB, 0, 0, 4'b0000, 0, 0, 1, 0, 0);
        tick();
        idle();
        bus.m_rn = 5'd3; bus.m_wreg = 1; bus.m_alu = 32'h11;
        bus.w_rn = 5'd3; bus.w_wreg = 1; bus.w_data = 32'h22;
        expect_out("fwd_mem_beats_wb", mk(32'h11, 32'hBBBB, 4'b0000, 1, 1, 0, 0, 5'd7, 32'hBBBB, 0));
        observe();
        bus.m_m2reg = 1;
        expect_out("fwd_load_in_mem_skipped", mk(32'h22, 32'hBBBB, 4'b0000, 1, 1, 0, 0, 5'd7, 32'hBBBB, 0));
        observe();
        bus.m_m2reg = 0; bus.m_rn = 5'd6;
        expect_out("fwd_rt_from_mem", mk(32'h22, 32'h11, 4'b0000, 1, 1, 0, 0, 5'd7, 32'h11, 0));
        observe();
        idle();
        tick();
        drive_id(1, 5'd0, 5'd0, 5'd8, 1, 1, 32'h55, 32'h66, 0, 0, 4'b0000, 0, 0, 1, 0, 0);
        tick();
        idle();
        bus.m_rn = 5'd0; bus.m_wreg = 1; bus.m_alu = 32'h11;
        bus.w_rn = 5'd0; bus.w_wreg = 1; bus.w_data = 32'h22;
        expect_out("fwd_r0_uses_stored", mk(32'h55, 32'h66, 4'b0000, 1, 1, 0, 0, 5'd8, 32'h66, 0));
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("[TB] FAIL %s: no output observed, required %s", n, fmt(e)); end
            else begin g = got_q.pop_front();
                if (g !== e) begin tests_failed++; $display("[TB] FAIL %s: got %s | required %s", n, fmt(g), fmt(e)); end
            end
        end
    endtask

    // lw r4 followed by add r5, r4, r1: one hazard cycle, one bubble, then WB forward.
    task automatic test_load_use();
        obs_t e, g; string n;
        idle();
        tick();
        drive_id(1, 5'd1, 5'd0, 5'd4, 1, 0, 32'h100, 32'h0, 32'd8, 0, 4'b0000, 1, 0, 1, 1, 0);
        tick();
        drive_id(1, 5'd4, 5'd1, 5'd5, 1, 1, 32'h0, 32'h3, 0, 0, 4'b0000, 0, 0, 1, 0, 0);
        expect_out("load_use_raised", mk(32'h100, 32'd8, 4'b0000, 1, 1, 1, 0, 5'd4, 32'h0, 1));
        observe();
        tick();
        bus.m_rn = 5'd4; bus.m_wreg = 1; bus.m_m2reg = 1; bus.m_alu = 32'h108;
        expect_out("load_use_bubble", mk(0, 0, 4'b0000, 0, 0, 0, 0, 5'd0, 0, 0));
        observe();
        tick();
        bus.m_wreg = 0; bus.m_m2reg = 0;
        bus.w_rn = 5'd4; bus.w_wreg = 1; bus.w_data = 32'hDEAD;
        expect_out("load_use_wb_forward", mk(32'hDEAD, 32'h3, 4'b0000, 1, 1, 0, 0, 5'd5, 32'h3, 0));
        observe();
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("[TB] FAIL %s: no output observed, required %s", n, fmt(e)); end
            else begin g = got_q.pop_front();
                if (g !== e) begin tests_failed++; $display("[TB] FAIL %s: got %s | required %s", n, fmt(g), fmt(e)); end
            end
        end
    endtask

    // A WB value present only in the first stall cycle must survive the stall.
    task automatic test_stall_refresh();
        obs_t e, g; string n;
        idle();
        drive_id(1, 5'd9, 5'd10, 5'd11, 1, 1, 32'h1, 32'h2, 0, 0, 4'b0001, 0, 0, 1, 0, 0);
        tick();
        drive_id(1, 5'd12, 5'd13, 5'd14, 0, 0, 32'hEE, 32'hFF, 0, 0, 4'b0101, 0, 0, 1, 0, 0);
        bus.stall = 1;
        bus.w_rn = 5'd9; bus.w_wreg = 1; bus.w_data = 32'h99;
        expect_out("stall_cycle1", mk(32'h99, 32'h2, 4'b0001, 1, 1, 0, 0, 5'd11, 32'h2, 0));
        observe();
        tick();
        bus.w_wreg = 0; bus.w_data = 32'h0;
        expect_out("stall_cycle2", mk(32'h99, 32'h2, 4'b0001, 1, 1, 0, 0, 5'd11, 32'h2, 0));
        observe();
        tick();
        expect_out("stall_cycle3", mk(32'h99, 32'h2, 4'b0001, 1, 1, 0, 0, 5'd11, 32'h2, 0));
        observe();
        idle();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("[TB] FAIL %s: no output observed, required %s", n, fmt(e)); end
            else begin g = got_q.pop_front();
                if (g !== e) begin tests_failed++; $display("[TB] FAIL %s: got %s | required %s", n, fmt(g), fmt(e)); end
            end
        end
    endtask

    // SLL takes sa on a; LUI takes the immediate on b.
    task automatic test_shift_imm();
        obs_t e, g; string n;
        idle();
        drive_id(1, 5'd0, 5'd2, 5'd3, 0, 1, 32'h0, 32'h1, 0, 5'd4, 4'b0011, 0, 1, 1, 0, 0);
        tick();
        expect_out("sll_shift_amount", mk(32'd4, 32'h1, 4'b0011, 1, 1, 0, 0, 5'd3, 32'h1, 0));
        observe();
        drive_id(1, 5'd0, 5'd5, 5'd5, 0, 0, 32'h77, 32'h5, 32'h1234, 0, 4'b0110, 1, 0, 1, 0, 0);
        tick();
        expect_out("lui_immediate", mk(32'h77, 32'h00001234, 4'b0110, 1, 1, 0, 0, 5'd5, 32'h5, 0));
        observe();
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("[TB] FAIL %s: no output observed, required %s", n, fmt(e)); end
            else begin g = got_q.pop_front();
                if (g !== e) begin tests_failed++; $display("[TB] FAIL %s: got %s | required %s", n, fmt(g), fmt(e)); end
            end
        end
    endtask

    // stall beats load_use (which stays high); flush beats both.
    task automatic test_flush_priority();
        obs_t e, g; string n;
        idle();
        tick();
        drive_id(1, 5'd1, 5'd0, 5'd4, 1, 0, 32'h100, 32'h0, 32'd8, 0, 4'b0000, 1, 0, 1, 1, 0);
        tick();
        drive_id(1, 5'd4, 5'd1, 5'd5, 1, 1, 32'h0, 32'h3, 0, 0, 4'b0000, 0, 0, 1, 0, 0);
        bus.stall = 1;
        expect_out("stall_load_use_raised", mk(32'h100, 32'd8, 4'b0000, 1, 1, 1, 0, 5'd4, 32'h0, 1));
        observe();
        tick();
        expect_out("stall_beats_load_use", mk(32'h100, 32'd8, 4'b0000, 1, 1, 1, 0, 5'd4, 32'h0, 1));
        observe();
        bus.flush = 1;
        tick();
        expect_out("flush_beats_all", mk(0, 0, 4'b0000, 0, 0, 0, 0, 5'd0, 0, 0));
        observe();
        idle();
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("[TB] FAIL %s: no output observed, required %s", n, fmt(e)); end
            else begin g = got_q.pop_front();
                if (g !== e) begin tests_failed++; $display("[TB] FAIL %s: got %s | required %s", n, fmt(g), fmt(e)); end
            end
        end
    endtask

    // Asynchronous reset in the middle of a stall throws the held instruction away.
    task automatic test_reset_mid_stall();
        obs_t e, g; string n;
        idle();
        drive_id(1, 5'd1, 5'd2, 5'd3, 0, 0, 32'h44, 32'h45, 0, 0, 4'b0100, 0, 0, 1, 0, 1);
        tick();
        idle();
        bus.stall = 1;
        tick();
        expect_out("stall_holds_instr", mk(32'h44, 32'h45, 4'b0100, 1, 1, 0, 1, 5'd3, 32'h45, 0));
        observe();
        resetn = 0;
        expect_out("reset_mid_stall", mk(0, 0, 4'b0000, 0, 0, 0, 0, 5'd0, 0, 0));
        observe();
        @(negedge clock);
        resetn = 1;
        idle();
        tick();
        expect_out("after_mid_stall_reset", mk(0, 0, 4'b0000, 0, 0, 0, 0, 5'd0, 0, 0));
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("[TB] FAIL %s: no output observed, required %s", n, fmt(e)); end
            else begin g = got_q.pop_front();
                if (g !== e) begin tests_failed++; $display("[TB] FAIL %s: got %s | required %s", n, fmt(g), fmt(e)); end
            end
        end
    endtask

    // Back-to-back random instructions with no forwarding or hazards in play.
    task automatic test_back_to_back();
        obs_t e, g; string n;
        idle();
        for (int i = 0; i < 8; i++) begin
            logic        v, aimm, sh, wr, m2, wm;
            logic [4:0]  rs, rt, rn, sa;
            logic [3:0]  op;
            logic [31:0] rsd, rtd, imm;
            v = 1'($urandom_range(0, 1)); aimm = 1'($urandom_range(0, 1));
            sh = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            m2 = 1'($urandom_range(0, 1)); wm = 1'($urandom_range(0, 1));
            rs = 5'($urandom); rt = 5'($urandom); rn = 5'($urandom); sa = 5'($urandom);
            op = 4'($urandom); rsd = $urandom; rtd = $urandom; imm = $urandom;
            drive_id(v, rs, rt, rn, 0, 0, rsd, rtd, imm, sa, op, aimm, sh, wr, m2, wm);
            expect_out($sformatf("b2b_%0d", i),
                       mk(sh ? {27'b0, sa} : rsd, aimm ? imm : rtd, op, v, wr & v, m2,
                          wm & v, rn, rtd, 1'b0));
            tick();
            observe();
        end
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); tests_run++;
            if (got_q.size() == 0) begin tests_failed++; $display("[TB] FAIL %s: no output observed, required %s", n, fmt(e)); end
            else begin g = got_q.pop_front();
                if (g !== e) begin tests_failed++; $display("[TB] FAIL %s: got %s | required %s", n, fmt(g), fmt(e)); end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 0;
        idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_stall_refresh();
        test_shift_imm();
        test_flush_priority();
        test_reset_mid_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
